// File: rtl/seg7_disp_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_disp_ctrl_if
// CPU register bus for the 7-segment display front end.
//   we     : write strobe, one cycle per write
//   addr   : register select (0 hex text, 1 point/LES, 2 ctrl, 3 status)
//   wdata  : write data
//   rdata  : read data, combinational from addr
// master modport = bus initiator (CPU side), slave modport = seg7_disp_ctrl.
// -----------------------------------------------------------------------------
interface seg7_disp_ctrl_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/seg7_disp_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_disp_ctrl
// Bus-facing front end of the 7-segment serial display path. CPU writes land in
// staging registers; a stable copy is presented to the segment driver and a
// one-cycle Start launches each serial transfer. busy covers the whole window.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active low
//   bus    slave modport of seg7_disp_ctrl_if (we, addr, wdata, rdata)
//   Hexs   out  displayed hex/segment text
//   point  out  decimal-point enables
//   LES    out  digit blank/flash enables
//   flash  out  blink phase (flash_en & fcnt[FLASH_DIV])
//   Start  out  one-cycle transfer launch
//   busy   out  transfer window active (LOAD or SHIFT)
//
// Build option
//   SEG7_AUTO_REFRESH_EN : when defined, adds the auto-refresh timer and the
//                          ctrl.auto_en bit; otherwise neither exists.
// -----------------------------------------------------------------------------
module seg7_disp_ctrl #(
    parameter int unsigned SHIFT_CYCLES   = 140,
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned FLASH_DIV      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_disp_ctrl_if.slave      bus,
    output logic [31:0]          Hexs,
    output logic [7:0]           point,
    output logic [7:0]           LES,
    output logic                 flash,
    output logic                 Start,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] fcnt_q, fcnt_d;

    logic [31:0] stg_hex_q, stg_hex_d;
    logic [7:0]  stg_pt_q, stg_pt_d;
    logic [7:0]  stg_les_q, stg_les_d;
    logic        flash_en_q, flash_en_d;
    logic        pending_q, pending_d;

    logic [31:0] hex_q, hex_d;
    logic [7:0]  pt_q, pt_d;
    logic [7:0]  les_q, les_d;

    logic        wr_hex, wr_ptles, wr_ctrl;
    logic        refresh_hit;
    logic        auto_en;
    logic        load;

    assign wr_hex   = bus.we && (bus.addr == 2'd0);
    assign wr_ptles = bus.we && (bus.addr == 2'd1);
    assign wr_ctrl  = bus.we && (bus.addr == 2'd2);

    // A display update is taken exactly on the IDLE->LOAD edge.
    assign load = (state_q == IDLE) && pending_q;

`ifdef SEG7_AUTO_REFRESH_EN
    logic        auto_en_q, auto_en_d;
    logic [31:0] rcnt_q, rcnt_d;

    always_comb begin
        auto_en_d   = auto_en_q;
        rcnt_d      = rcnt_q;
        refresh_hit = 1'b0;
        if (wr_ctrl) begin
            auto_en_d = bus.wdata[0];
        end
        if (!auto_en_q) begin
            rcnt_d = '0;
        end else if (rcnt_q == 32'(REFRESH_CYCLES - 1)) begin
            rcnt_d      = '0;
            refresh_hit = 1'b1;
        end else begin
            rcnt_d = rcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            auto_en_q <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            auto_en_q <= auto_en_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign auto_en = auto_en_q;
`else
    assign refresh_hit = 1'b0;
    assign auto_en     = 1'b0;
`endif

    // Staging, control, pending and free-running blink counter.
    always_comb begin
        stg_hex_d  = stg_hex_q;
        stg_pt_d   = stg_pt_q;
        stg_les_d  = stg_les_q;
        flash_en_d = flash_en_q;
        fcnt_d     = fcnt_q + 32'd1;

        if (wr_hex) begin
            stg_hex_d = bus.wdata;
        end
        if (wr_ptles) begin
            stg_pt_d  = bus.wdata[15:8];
            stg_les_d = bus.wdata[7:0];
        end
        if (wr_ctrl) begin
            flash_en_d = bus.wdata[1];
        end

        // A write on the load edge re-arms pending, so the new value gets
        // its own transfer right after the current one.
        pending_d = (pending_q && !load) || wr_hex || wr_ptles || refresh_hit;
    end

    // Transfer FSM: next state, window counter and output snapshot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        pt_d    = pt_q;
        les_d   = les_q;

        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = LOAD;
                    hex_d   = stg_hex_q;
                    pt_d    = stg_pt_q;
                    les_d   = stg_les_q;
                end
            end
            LOAD: begin
                // SHIFT runs for SHIFT_CYCLES-1 cycles: counter values N-2..0.
                state_d = SHIFT;
                cnt_d   = 32'(SHIFT_CYCLES - 2);
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            stg_hex_q  <= '0;
            stg_pt_q   <= '0;
            stg_les_q  <= '0;
            flash_en_q <= 1'b0;
            pending_q  <= 1'b1;
            hex_q      <= '0;
            pt_q       <= '0;
            les_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            stg_hex_q  <= stg_hex_d;
            stg_pt_q   <= stg_pt_d;
            stg_les_q  <= stg_les_d;
            flash_en_q <= flash_en_d;
            pending_q  <= pending_d;
            hex_q      <= hex_d;
            pt_q       <= pt_d;
            les_q      <= les_d;
        end
    end

    // Only one bit of the blink counter reaches an output.
    logic unused_fcnt;
    assign unused_fcnt = ^fcnt_q;

    always_comb begin
        bus.rdata = '0;
        unique case (bus.addr)
            2'd0:    bus.rdata = stg_hex_q;
            2'd1:    bus.rdata = {16'd0, stg_pt_q, stg_les_q};
            2'd2:    bus.rdata = {30'd0, flash_en_q, auto_en};
            default: bus.rdata = {30'd0, pending_q, busy};
        endcase
    end

    assign Hexs  = hex_q;
    assign point = pt_q;
    assign LES   = les_q;
    assign flash = flash_en_q & fcnt_q[FLASH_DIV];
    assign Start = (state_q == LOAD);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_disp_ctrl
// Directed bench for seg7_disp_ctrl with SHIFT_CYCLES=8, REFRESH_CYCLES=16,
// FLASH_DIV=1. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_disp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        flash;
    logic        Start;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_disp_ctrl_if bus_if ();

    seg7_disp_ctrl #(
        .SHIFT_CYCLES   (8),
        .REFRESH_CYCLES (16),
        .FLASH_DIV      (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .Hexs  (Hexs),
        .point (point),
        .LES   (LES),
        .flash (flash),
        .Start (Start),
        .busy  (busy)
    );

    // Bounded wait for Start at falling edges; a timeout is a failed check.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (Start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (Start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: Start not seen within 40 cycles", tag);
        end
    endtask

    // Single write: present at a falling edge, captured at the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(negedge clk);
        bus_if.we    = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int s;
        rst          = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 2'd3;
        bus_if.wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (Hexs !== 32'h0 || point !== 8'h0 || LES !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%h expected 0/0/0", Hexs, point, LES);
        end
        checks++;
        if (Start !== 1'b0 || busy !== 1'b0 || flash !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got start=%b busy=%b flash=%b expected 0/0/0", Start, busy, flash);
        end
        checks++;
        if (bus_if.rdata !== 32'h2) begin
            errors++;
            $display("FAIL reset_status: got %h expected 00000002", bus_if.rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (Start !== 1'b1 || Hexs !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_start: got start=%b hexs=%h expected 1/0", Start, Hexs);
        end
        n = 0;
        s = 0;
        while (busy === 1'b1 && n < 20) begin
            if (Start === 1'b1) s++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d expected 8", n);
        end
        checks++;
        if (s != 1) begin
            errors++;
            $display("FAIL reset_start_count: got %0d expected 1", s);
        end
    endtask

    task automatic test_write_idle();
        int n;
        bus_write(2'd0, 32'h1234ABCD);
        checks++;
        if (Start !== 1'b0) begin
            errors++;
            $display("FAIL idle_write_early: got start=%b expected 0", Start);
        end
        @(negedge clk);
        checks++;
        if (Start !== 1'b1 || Hexs !== 32'h1234ABCD) begin
            errors++;
            $display("FAIL idle_write_start: got start=%b hexs=%h expected 1/1234abcd", Start, Hexs);
        end
        bus_if.addr = 2'd3;
        n = 1;
        @(negedge clk);
        #1;
        checks++;
        if (bus_if.rdata !== 32'h1) begin
            errors++;
            $display("FAIL idle_write_status: got %h expected 00000001", bus_if.rdata);
        end
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL idle_write_busy_len: got %0d expected 8", n);
        end
    endtask

    task automatic test_coalesce();
        int n;
        int g;
        int s;
        int bad;
        bus_write(2'd0, 32'h11111111);
        wait_start("coalesce_first");
        checks++;
        if (Hexs !== 32'h11111111) begin
            errors++;
            $display("FAIL coalesce_first_hexs: got %h expected 11111111", Hexs);
        end
        @(negedge clk);
        bus_if.we    = 1'b1;
        bus_if.addr  = 2'd1;
        bus_if.wdata = 32'h0000A50F;
        @(negedge clk);
        bus_if.addr  = 2'd0;
        bus_if.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_if.we    = 1'b0;
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && n < 20) begin
            if (Hexs !== 32'h11111111 || point !== 8'h0 || LES !== 8'h0 || Start !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL coalesce_stable: got %0d disturbed cycles expected 0", bad);
        end
        g = 0;
        while (Start !== 1'b1 && g < 20) begin
            g++;
            @(negedge clk);
        end
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL coalesce_gap: got %0d idle cycles expected 1", g);
        end
        checks++;
        if (Hexs !== 32'hDEADBEEF || point !== 8'hA5 || LES !== 8'h0F) begin
            errors++;
            $display("FAIL coalesce_values: got %h/%h/%h expected deadbeef/a5/0f", Hexs, point, LES);
        end
        s = 0;
        for (int i = 0; i < 20; i++) begin
            if (Start === 1'b1) s++;
            @(negedge clk);
        end
        checks++;
        if (s != 1) begin
            errors++;
            $display("FAIL coalesce_start_count: got %0d expected 1", s);
        end
    endtask

    task automatic test_load_edge();
        int n;
        int g;
        bus_if.we    = 1'b1;
        bus_if.addr  = 2'd0;
        bus_if.wdata = 32'h5;
        @(negedge clk);
        bus_if.wdata = 32'h1;
        @(negedge clk);
        checks++;
        if (Start !== 1'b1 || Hexs !== 32'h5) begin
            errors++;
            $display("FAIL load_edge_first: got start=%b hexs=%h expected 1/00000005", Start, Hexs);
        end
        bus_if.we   = 1'b0;
        bus_if.addr = 2'd3;
        #1;
        checks++;
        if (bus_if.rdata !== 32'h3) begin
            errors++;
            $display("FAIL load_edge_status: got %h expected 00000003", bus_if.rdata);
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        g = 0;
        while (Start !== 1'b1 && g < 20) begin
            g++;
            @(negedge clk);
        end
        checks++;
        if (g != 1 || Hexs !== 32'h1) begin
            errors++;
            $display("FAIL load_edge_second: got gap=%0d hexs=%h expected 1/00000001", g, Hexs);
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_auto_refresh();
        int s;
        int first;
        logic [31:0] exp_ctrl;
        int exp_s;
        int exp_first;
`ifdef SEG7_AUTO_REFRESH_EN
        exp_ctrl  = 32'h1;
        exp_s     = 3;
        exp_first = 17;
`else
        exp_ctrl  = 32'h0;
        exp_s     = 0;
        exp_first = 0;
`endif
        bus_write(2'd2, 32'h1);
        bus_if.addr = 2'd2;
        #1;
        checks++;
        if (bus_if.rdata !== exp_ctrl) begin
            errors++;
            $display("FAIL auto_ctrl_read: got %h expected %h", bus_if.rdata, exp_ctrl);
        end
        s     = 0;
        first = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (Start === 1'b1) begin
                s++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (s != exp_s) begin
            errors++;
            $display("FAIL auto_start_count: got %0d expected %0d", s, exp_s);
        end
        checks++;
        if (first != exp_first) begin
            errors++;
            $display("FAIL auto_first_start: got cycle %0d expected %0d", first, exp_first);
        end
        bus_write(2'd2, 32'h0);
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_quiesce: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_flash_reset();
        logic f [8];
        bus_write(2'd2, 32'h2);
        bus_if.addr = 2'd2;
        #1;
        checks++;
        if (bus_if.rdata !== 32'h2) begin
            errors++;
            $display("FAIL flash_ctrl_read: got %h expected 00000002", bus_if.rdata);
        end
        for (int i = 0; i < 8; i++) begin
            f[i] = flash;
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (f[i+2] !== ~f[i]) begin
                errors++;
                $display("FAIL flash_toggle_%0d: got %b expected %b", i, f[i+2], ~f[i]);
            end
        end
        bus_write(2'd0, 32'hCAFE0001);
        wait_start("flash_reset_start");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (Hexs !== 32'h0 || point !== 8'h0 || LES !== 8'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%h/%h expected 0/0/0", Hexs, point, LES);
        end
        checks++;
        if (Start !== 1'b0 || busy !== 1'b0 || flash !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: got start=%b busy=%b flash=%b expected 0/0/0", Start, busy, flash);
        end
        bus_if.addr = 2'd3;
        #1;
        checks++;
        if (bus_if.rdata !== 32'h2) begin
            errors++;
            $display("FAIL midreset_status: got %h expected 00000002", bus_if.rdata);
        end
        bus_if.addr = 2'd2;
        #1;
        checks++;
        if (bus_if.rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_ctrl_read: got %h expected 00000000", bus_if.rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (Start !== 1'b1 || Hexs !== 32'h0) begin
            errors++;
            $display("FAIL midreset_restart: got start=%b hexs=%h expected 1/0", Start, Hexs);
        end
    endtask

    initial begin
        test_reset();
        test_write_idle();
        test_coalesce();
        test_load_edge();
        test_auto_refresh();
        test_flash_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/seg7_disp_ctrl.md
# seg7_disp_ctrl

Bus-facing front end for the 7-segment serial display path. Accepts CPU register writes of display text (Hexs, point, LES), holds them in staging registers, and presents a stable copy to the downstream segment driver. Issues a one-cycle `Start` to launch each serial transfer, and marks `busy` while that transfer is in flight. Also generates the `flash` blink signal and an optional periodic refresh.

## Interface
- `SHIFT_CYCLES`, default 140: length of one transfer window in clocks, including the Start cycle; must be ≥ 2.
- `REFRESH_CYCLES`, default 1_000_000: period of the auto-refresh timer in clocks.
- `FLASH_DIV`, default 24: index of the free-running counter bit that drives `flash`.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `we`  in  1  bus write strobe, one cycle per write.
- `addr`  in  2  register select.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational from `addr`.
- `Hexs`  out  32  displayed hex/segment text.
- `point`  out  8  decimal-point enables.
- `LES`  out  8  digit blank/flash enables.
- `flash`  out  1  blink phase.
- `Start`  out  1  one-cycle transfer launch to the serial driver.
- `busy`  out  1  transfer window active.

## Operation
- **Register map** (a write takes effect at the clock edge where `we`=1):
  - 0: `stg_hex`[31:0].
  - 1: `stg_pt` = wdata[15:8], `stg_les` = wdata[7:0].
  - 2: ctrl; bit0 = `auto_en`, bit1 = `flash_en`; other bits read 0.
  - 3: status, read-only; bit0 = `busy`, bit1 = `pending`. Writes to addr 3 are ignored.
- **Reads:** addr 0/1/2 return the staging/ctrl values with unused bits 0.
- **Pending:** a write to addr 0 or 1 sets `pending`. A refresh-timer expiry also sets `pending`.
- **FSM:** states IDLE, LOAD, SHIFT.
  - IDLE & `pending`: next state LOAD. On that same edge, `Hexs`/`point`/`LES` <= staging and `pending` clears.
  - LOAD: `Start`=1 for exactly this cycle; next state SHIFT.
  - SHIFT: a down-counter runs for SHIFT_CYCLES−1 cycles, then the FSM returns to IDLE.
  - `busy` = (state ≠ IDLE).
- **Output stability:** `Hexs`/`point`/`LES` change only on the IDLE→LOAD edge. They never change during LOAD or SHIFT.
- **Write in the same cycle as IDLE→LOAD:** the old staging value is copied to the outputs. The write lands in staging and `pending` stays set, so a second transfer follows immediately after SHIFT.
- **Writes during LOAD/SHIFT:** update staging and set `pending`. Multiple writes coalesce into one follow-up transfer that carries the last values.
- **Flash:** free-running 32-bit counter `fcnt`. `flash` = `flash_en` & `fcnt`[FLASH_DIV].
- **Refresh timer:** counts while `auto_en`=1. At REFRESH_CYCLES−1 it wraps to 0 and sets `pending`. `auto_en`=0 holds it at 0.
- **Reset values:**
  - state IDLE; all outputs 0 (`Hexs`=0, `point`=0, `LES`=0, `flash`=0, `Start`=0, `busy`=0).
  - staging 0; ctrl 0; counters 0; `pending`=1, so the display is cleared right after reset.
- **Reset mid-transfer:** aborts the transfer. All of the reset values above apply on the next edge.

## Timing
- First Start after reset: `rst` rises before edge N. The IDLE→LOAD transition occurs at edge N and `Start` is high in cycle N.
- Write-to-Start latency from IDLE: write at edge k; IDLE→LOAD at edge k+1; `Start` high in cycle k+1.
- `busy` high for exactly SHIFT_CYCLES consecutive cycles per transfer.
- Back-to-back transfers: at least one IDLE cycle between SHIFT end and the next LOAD.
- `Start` is never asserted while a previous transfer's SHIFT is active.

## Configuration
- Macro `SEG7_AUTO_REFRESH_EN`.
- **Defined:** refresh timer and ctrl bit0 are implemented as described above.
- **Undefined:** no timer logic is present. ctrl bit0 is not stored and reads 0. `pending` is set only by writes and by reset.

## Test plan
Benches use SHIFT_CYCLES=8, REFRESH_CYCLES=16, FLASH_DIV=1.
- **Reset release:** release reset → `Start` pulses in the first cycle after release; `Hexs`=0; `busy` high 8 cycles, then low.
- **Write from IDLE:** write addr0 = 32'h1234ABCD in IDLE → `Start` next cycle; `Hexs`=32'h1234ABCD on that edge; `busy` 8 cycles; status reads 32'h1 during SHIFT.
- **Coalesced writes:** during SHIFT, write addr1 = 32'h0000A50F, then addr0 = 32'hDEADBEEF → outputs unchanged until SHIFT ends. Then exactly one more `Start` with `point`=8'hA5, `LES`=8'h0F, `Hexs`=32'hDEADBEEF.
- **Write on the load edge:** write addr0 = 32'h1 on the same edge as IDLE→LOAD → that transfer carries the old value. A second `Start` follows with `Hexs`=32'h1.
- **Auto-refresh:** write ctrl = 32'h1 → with the macro, `Start` recurs (timer every 16 cycles, serialized with busy). Without the macro: no `Start` and ctrl reads 0.
- **Flash and mid-transfer reset:** ctrl = 32'h2 → `flash` toggles every 2 cycles. Then drive `rst` low mid-SHIFT → next edge all outputs 0 and `flash`=0. After release, a new `Start`.
